// File: rtl/music_sequencer.sv
`timescale 1ns/1ps
// Purpose : steps through a song in the note ROM, one tone-generator note at a time.
// Latency : start -> note_en high on the 3rd cycle; note_finish -> next note after GAP_CYCLES+2 low cycles.
// Backpressure: none; each note is held until the tone generator reports finish, stop aborts at once.
//
// Ports:
//   clk, rst (sync, active high)      clock and reset
//   start, stop, loop, song_base       player control
//   rom_addr / rom_data                synchronous note ROM, data one cycle after address
//   note_en, note_scale, note_time     tone generator command
//   note_finish                        tone generator finish (slow domain, synchronized here)
//   busy, done                         status: not-idle level, natural end-of-song pulse
module music_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int MAX_NOTES  = 256,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] song_base,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              note_en,
  output logic [4:0]        note_scale,
  output logic [10:0]       note_time,
  input  logic              note_finish,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(MAX_NOTES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [CNT_W-1:0]   note_cnt, cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [4:0]         scale_n;
  logic [10:0]        time_n;
  logic               fin_m, fin_s;

  logic [4:0]         rom_scale;
  logic [10:0]        rom_ms;
  logic               song_end;

  assign rom_scale = rom_data[15:11];
  assign rom_ms    = rom_data[10:0];
  // A zero duration marks the end; a runaway song without a marker ends after MAX_NOTES.
  assign song_end  = (rom_ms == 11'd0) || (note_cnt == CNT_W'(MAX_NOTES));

  // note_finish comes from the slow tone-generator domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_m <= 1'b0;
      fin_s <= 1'b0;
    end else begin
      fin_m <= note_finish;
      fin_s <= fin_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      note_cnt   <= '0;
      gap_cnt    <= '0;
      note_scale <= 5'd0;
      note_time  <= 11'd0;
      note_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      rom_addr   <= addr_n;
      note_cnt   <= cnt_n;
      gap_cnt    <= gap_n;
      note_scale <= scale_n;
      note_time  <= time_n;
      // Status outputs are registered copies of the state being entered.
      note_en    <= (state_n == S_PLAY);
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = rom_addr;
    cnt_n   = note_cnt;
    gap_n   = gap_cnt;
    scale_n = note_scale;
    time_n  = note_time;

    case (state)
      S_IDLE: begin
        if (start) begin
          addr_n  = song_base;
          cnt_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        if (song_end) begin
          if (loop) begin
            addr_n  = song_base;
            cnt_n   = '0;
            state_n = S_FETCH;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          // Scales above 21 have no tone; play them as a rest of the same length.
          scale_n = (rom_scale > 5'd21) ? 5'd0 : rom_scale;
          time_n  = rom_ms;
          state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (fin_s) begin
          gap_n   = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        // The gap also gives the finish synchronizer time to drain before the next PLAY.
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          addr_n  = rom_addr + ADDR_W'(1);
          cnt_n   = note_cnt + CNT_W'(1);
          state_n = S_FETCH;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // stop overrides everything, including a same-cycle start.
    if (stop) begin
      state_n = S_IDLE;
      addr_n  = rom_addr;
      cnt_n   = note_cnt;
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
`timescale 1ns/1ps
module tb_music_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop;
  logic [7:0]  song_base, rom_addr;
  logic [15:0] rom_data;
  logic        note_en, note_finish, busy, done;
  logic [4:0]  note_scale;
  logic [10:0] note_time;

  logic        fin_drv, auto_fin, tg_fin;
  int          en_cnt;
  int          done_total = 0;
  int          tests = 0;
  int          fails = 0;

  logic [15:0] rom [0:255];

  always #5 clk = ~clk;

  music_sequencer #(.ADDR_W(8), .MAX_NOTES(256), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .song_base(song_base), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_en(note_en), .note_scale(note_scale), .note_time(note_time),
    .note_finish(note_finish), .busy(busy), .done(done)
  );

  // Synchronous note ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Tone generator stand-in: finishes a few cycles into a note, clears when enable drops.
  always @(posedge clk) begin
    if (!auto_fin || !note_en) begin
      en_cnt <= 0;
      tg_fin <= 1'b0;
    end else begin
      en_cnt <= en_cnt + 1;
      if (en_cnt >= 3) tg_fin <= 1'b1;
    end
  end
  assign note_finish = auto_fin ? tg_fin : fin_drv;

  always @(posedge clk) if (done) done_total = done_total + 1;

  typedef struct {
    logic        start, stop, fin;
    logic        en, busy, done;
    logic [7:0]  addr;
    logic [4:0]  scale;
    logic [10:0] tm;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic s, input logic p, input logic f,
                     input logic e, input logic b, input logic d,
                     input logic [7:0] a, input logic [4:0] sc, input logic [10:0] t);
    vec_t v;
    v.start = s; v.stop = p; v.fin = f;
    v.en = e; v.busy = b; v.done = d;
    v.addr = a; v.scale = sc; v.tm = t;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_en(input logic lvl, input string nm);
    int n;
    n = 0;
    while (note_en !== lvl && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (note_en !== lvl) begin
      fails++;
      $display("FAIL %s: note_en=%0b after %0d cycles, expected %0b", nm, note_en, n, lvl);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy=%0b after %0d cycles, expected 0", nm, busy, n);
    end
  endtask

  task automatic pulse_start(input logic [7:0] b);
    song_base = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      start     = tbl[i].start;
      stop      = tbl[i].stop;
      fin_drv   = tbl[i].fin;
      song_base = 8'h10;
      tick();
      chk($sformatf("%s[%0d].note_en", tag, i),    int'(note_en),    int'(tbl[i].en));
      chk($sformatf("%s[%0d].busy", tag, i),       int'(busy),       int'(tbl[i].busy));
      chk($sformatf("%s[%0d].done", tag, i),       int'(done),       int'(tbl[i].done));
      chk($sformatf("%s[%0d].rom_addr", tag, i),   int'(rom_addr),   int'(tbl[i].addr));
      chk($sformatf("%s[%0d].note_scale", tag, i), int'(note_scale), int'(tbl[i].scale));
      chk($sformatf("%s[%0d].note_time", tag, i),  int'(note_time),  int'(tbl[i].tm));
    end
    start = 1'b0; stop = 1'b0; fin_drv = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;

    // Cycle-by-cycle song: 0x10 = 8/300 ms, 0x11 = rest/100 ms, 0x12 = end, loop=0.
    // Columns: start stop fin | note_en busy done rom_addr scale time (after the edge)
    add(1,0,0, 0,1,0, 8'h10, 5'd0, 11'd0);
    add(0,0,0, 0,1,0, 8'h10, 5'd0, 11'd0);
    add(0,0,0, 1,1,0, 8'h10, 5'd8, 11'd300);
    add(0,0,1, 1,1,0, 8'h10, 5'd8, 11'd300);
    add(0,0,1, 1,1,0, 8'h10, 5'd8, 11'd300);
    add(0,0,1, 0,1,0, 8'h10, 5'd8, 11'd300);
    add(0,0,0, 0,1,0, 8'h10, 5'd8, 11'd300);
    add(0,0,0, 0,1,0, 8'h10, 5'd8, 11'd300);
    add(0,0,0, 0,1,0, 8'h10, 5'd8, 11'd300);
    add(0,0,0, 0,1,0, 8'h11, 5'd8, 11'd300);
    add(0,0,0, 0,1,0, 8'h11, 5'd8, 11'd300);
    add(0,0,0, 1,1,0, 8'h11, 5'd0, 11'd100);
    add(0,0,1, 1,1,0, 8'h11, 5'd0, 11'd100);
    add(0,0,1, 1,1,0, 8'h11, 5'd0, 11'd100);
    add(0,0,1, 0,1,0, 8'h11, 5'd0, 11'd100);
    add(0,0,0, 0,1,0, 8'h11, 5'd0, 11'd100);
    add(0,0,0, 0,1,0, 8'h11, 5'd0, 11'd100);
    add(0,0,0, 0,1,0, 8'h11, 5'd0, 11'd100);
    add(0,0,0, 0,1,0, 8'h12, 5'd0, 11'd100);
    add(0,0,0, 0,1,0, 8'h12, 5'd0, 11'd100);
    add(0,0,0, 0,1,1, 8'h12, 5'd0, 11'd100);
    add(0,0,0, 0,0,0, 8'h12, 5'd0, 11'd100);
    add(0,0,0, 0,0,0, 8'h12, 5'd0, 11'd100);

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h10] = {5'd8, 11'd300};
    rom[8'h11] = {5'd0, 11'd100};
    rom[8'h12] = 16'h0000;
    rom[8'h20] = {5'd25, 11'd50};
    rom[8'h21] = 16'h0000;
    rom[8'hFF] = {5'd3, 11'd200};
    rom[8'h00] = {5'd5, 11'd120};
    rom[8'h01] = 16'h0000;

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    song_base = 8'h00; fin_drv = 1'b0; auto_fin = 1'b0;
    tick(); tick();
    chk("reset.note_en", int'(note_en), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.rom_addr", int'(rom_addr), 0);
    chk("reset.note_scale", int'(note_scale), 0);
    chk("reset.note_time", int'(note_time), 0);
    rst = 1'b0;
    tick();

    // 1: two-note song, natural end.
    run_table("s1");

    // 2: same song looping; third note is the first one again.
    auto_fin = 1'b1; loop = 1'b1;
    base = done_total;
    pulse_start(8'h10);
    wait_en(1'b1, "s2.note1_on");
    chk("s2.note1_scale", int'(note_scale), 8);
    wait_en(1'b0, "s2.note1_off");
    wait_en(1'b1, "s2.rest_on");
    chk("s2.rest_scale", int'(note_scale), 0);
    chk("s2.rest_time", int'(note_time), 100);
    wait_en(1'b0, "s2.rest_off");
    wait_en(1'b1, "s2.replay_on");
    chk("s2.replay_addr", int'(rom_addr), 8'h10);
    chk("s2.replay_scale", int'(note_scale), 8);
    chk("s2.replay_time", int'(note_time), 300);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("s2.stop_busy", int'(busy), 0);
    chk("s2.stop_note_en", int'(note_en), 0);
    chk("s2.stop_done", int'(done), 0);
    chk("s2.done_count", done_total - base, 0);
    loop = 1'b0;
    tick();

    // 3: illegal scale plays as a rest.
    pulse_start(8'h20);
    wait_en(1'b1, "s3.note_on");
    chk("s3.scale", int'(note_scale), 0);
    chk("s3.time", int'(note_time), 50);
    wait_idle("s3.finish");

    // 4: address wrap 0xFF -> 0x00 -> 0x01.
    base = done_total;
    pulse_start(8'hFF);
    wait_en(1'b1, "s4.note1_on");
    chk("s4.note1_addr", int'(rom_addr), 8'hFF);
    chk("s4.note1_scale", int'(note_scale), 3);
    chk("s4.note1_time", int'(note_time), 200);
    wait_en(1'b0, "s4.note1_off");
    wait_en(1'b1, "s4.note2_on");
    chk("s4.note2_addr", int'(rom_addr), 8'h00);
    chk("s4.note2_scale", int'(note_scale), 5);
    chk("s4.note2_time", int'(note_time), 120);
    wait_idle("s4.finish");
    chk("s4.end_addr", int'(rom_addr), 8'h01);
    chk("s4.done_count", done_total - base, 1);

    // 5a: start and stop together stay idle.
    auto_fin = 1'b0;
    song_base = 8'h10; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("s5.startstop_busy", int'(busy), 0);
    tick();
    chk("s5.startstop_busy_later", int'(busy), 0);

    // 5b: start during PLAY is ignored.
    pulse_start(8'h10);
    wait_en(1'b1, "s5.note_on");
    pulse_start(8'h20);
    tick(); tick();
    chk("s5.busy_start_en", int'(note_en), 1);
    chk("s5.busy_start_scale", int'(note_scale), 8);
    chk("s5.busy_start_time", int'(note_time), 300);
    chk("s5.busy_start_addr", int'(rom_addr), 8'h10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("s5.stop_busy", int'(busy), 0);
    tick();

    // 6: reset in the middle of a note, then a fresh run of song 1.
    pulse_start(8'h10);
    wait_en(1'b1, "s6.note_on");
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6.rst_note_en", int'(note_en), 0);
    chk("s6.rst_busy", int'(busy), 0);
    chk("s6.rst_addr", int'(rom_addr), 0);
    chk("s6.rst_scale", int'(note_scale), 0);
    tick();
    run_table("s6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
